// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce_sync input conditioner.
package debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_RISE_WAIT = 2'd1,
    S_HIGH      = 2'd2,
    S_FALL_WAIT = 2'd3
  } state_t;

  // Fewer than two flops gives no metastability settling time.
  localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/debounce_sync_sync_chain.sv
// Synchroniser shift register for an asynchronous level input.
// The last stage is the only value the rest of the design may look at.
module sync_chain #(
  parameter int   STAGES      = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rstb,
  input  logic din,
  output logic s_out
);

  logic [STAGES-1:0] sr;

  // Shift din toward s_out one stage per clock; reset preloads the idle level.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      sr <= {STAGES{RESET_LEVEL}};
    end else begin
      sr <= {sr[STAGES-2:0], din};
    end
  end

  assign s_out = sr[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Debouncer: synchronises a bouncy level input and accepts a change only
// after STABLE_CYCLES consecutive samples of the new level.
// Optional feature macro: DEBOUNCE_PULSE_EN adds rise_p/fall_p edge pulses.
//
// state       | meaning
// S_LOW       | q=0, input agrees with q
// S_RISE_WAIT | q=0, timing a candidate 0->1 change
// S_HIGH      | q=1, input agrees with q
// S_FALL_WAIT | q=1, timing a candidate 1->0 change
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 1000,
  parameter int   CNT_W         = 16,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic rstb,
  input  logic din,
  output logic q,
  output logic busy
`ifdef DEBOUNCE_PULSE_EN
  ,
  output logic rise_p,
  output logic fall_p
`endif
);

  // Clamp so an out-of-range setting still elaborates to a working chain.
  localparam int SYNC_N = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             s_in;
  logic             accept_rise;
  logic             accept_fall;

  sync_chain #(
    .STAGES      (SYNC_N),
    .RESET_LEVEL (RESET_LEVEL)
  ) u_sync (
    .clk   (clk),
    .rstb  (rstb),
    .din   (din),
    .s_out (s_in)
  );

  // The candidate has held for the full window on this edge.
  assign accept_rise = (state == S_RISE_WAIT) && s_in && (cnt == CNT_LAST);
  assign accept_fall = (state == S_FALL_WAIT) && !s_in && (cnt == CNT_LAST);
  assign busy        = (state == S_RISE_WAIT) || (state == S_FALL_WAIT);

  // FSM, stability counter and output level; any mismatch sample restarts timing.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state <= RESET_LEVEL ? S_HIGH : S_LOW;
      cnt   <= '0;
      q     <= RESET_LEVEL;
    end else begin
      case (state)
        S_LOW: begin
          if (s_in) begin
            state <= S_RISE_WAIT;
            cnt   <= CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end
        S_RISE_WAIT: begin
          if (!s_in) begin
            state <= S_LOW;
            cnt   <= '0;
          end else if (accept_rise) begin
            state <= S_HIGH;
            q     <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_HIGH: begin
          if (!s_in) begin
            state <= S_FALL_WAIT;
            cnt   <= CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end
        S_FALL_WAIT: begin
          if (s_in) begin
            state <= S_HIGH;
            cnt   <= '0;
          end else if (accept_fall) begin
            state <= S_LOW;
            q     <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= S_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef DEBOUNCE_PULSE_EN
  // Edge pulses register on the same edge that flips q, so they line up
  // with the first cycle of the new level.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      rise_p <= 1'b0;
      fall_p <= 1'b0;
    end else begin
      rise_p <= accept_rise;
      fall_p <= accept_fall;
    end
  end
`endif

endmodule
